rom_port_arbiter: RTL
=====================

Name: rom_port_arbiter

Overview:
- Shares the single 16-bit instruction/constant ROM port between two requesters: instruction fetch and data load (constant-table reads).
- Sequences each access through a fixed wait-state counter, so a slower or registered ROM can replace the combinational one without requester changes.
- Sits between the fetch/load units and the rom instance. Drives ROM Address and captures RomOut into per-requester data registers.

Parameters:
- ADDR_W, 16, address width of ROM and both requesters
- DATA_W, 16, ROM word width
- WAIT_CYCLES, 0, extra ROM wait cycles per access (legal 0..15)
- CNT_W, 4, width of wait counter; must hold WAIT_CYCLES

Ports:
- Clk  in  1  system clock, rising edge
- ResetN  in  1  asynchronous, active-low reset
- FetchReq  in  1  fetch request; held with FetchAddr stable until FetchGnt
- FetchAddr  in  ADDR_W  fetch word address
- FetchGnt  out  1  combinational; request accepted at this rising edge
- FetchValid  out  1  registered one-cycle pulse; FetchData valid
- FetchData  out  DATA_W  registered fetch read data
- LoadReq  in  1  load request; same rules as FetchReq
- LoadAddr  in  ADDR_W  load word address
- LoadGnt  out  1  combinational accept for load
- LoadValid  out  1  registered one-cycle pulse; LoadData valid
- LoadData  out  DATA_W  registered load read data
- RomAddress  out  ADDR_W  registered address to rom Address
- RomData  in  DATA_W  from rom RomOut
- Busy  out  1  high in ACCESS state

Behaviour:
- States:
  - IDLE: no access in flight.
  - ACCESS: registers Owner (FETCH/LOAD) and WaitCnt.
- Accept window: state==IDLE, or state==ACCESS && WaitCnt==0 (completion cycle).
- Gnt rules:
  - XGnt = accept window && XReq && arbitration winner == X.
  - At most one Gnt high per cycle.
  - Gnt never high without its Req.
- On an accepting edge:
  - RomAddress <= winner address.
  - Owner <= winner.
  - WaitCnt <= WAIT_CYCLES.
  - state <= ACCESS.
- ACCESS, WaitCnt!=0: WaitCnt decrements each edge. RomAddress holds.
- ACCESS, WaitCnt==0 edge:
  - Owner's data register <= RomData.
  - Owner's Valid pulses high for the next cycle.
  - Then state <= ACCESS with the new owner if a Gnt occurred, else IDLE.
- Latency: Req sampled with Gnt at edge E0 -> Valid/Data high in cycle after edge E0+1+WAIT_CYCLES.
- Throughput: one access per 1+WAIT_CYCLES cycles. Back-to-back with no idle cycle.
- Default arbitration is fixed priority: Load beats Fetch.
- Non-owner data register and Valid are unchanged by an access. Data registers hold their last value until the next capture.
- Simultaneous completion and new request: capture and new accept on the same edge. The new address appears on RomAddress the following cycle.
- Req dropped before Gnt: the request is silently withdrawn. No access occurs.
- Address wrap: no arithmetic on addresses. 16'hFFFF is passed unchanged.
- Reset (async, any state, including mid-access):
  - state=IDLE, WaitCnt=0, Owner=FETCH, RomAddress=0.
  - FetchData=LoadData=0, FetchValid=LoadValid=0, Busy=0.
  - Gnt outputs are 0 while ResetN is low.
  - The in-flight access is discarded. No Valid is produced for it after reset release.

Optional Feature:
- Macro: ROM_ARB_ROUND_ROBIN_EN.
- Defined:
  - Round-robin arbitration. A LastOwner register (reset FETCH) is updated on each grant.
  - When both request, the requester that did not win last gets the grant.
- Undefined:
  - Fixed priority, Load over Fetch. No LastOwner register.
  - Fetch can starve under continuous load requests.

Test Plan:
- Reset, WAIT_CYCLES=0, FetchReq=1, FetchAddr=16'h0010, ROM[0x10]=16'hA5A5 -> FetchGnt high in first cycle; FetchValid pulse and FetchData=16'hA5A5 one cycle later; LoadValid stays 0.
- WAIT_CYCLES=3, LoadReq with LoadAddr=16'h0200 -> Busy high 4 cycles; LoadValid 4 cycles after grant edge; RomAddress=16'h0200 throughout.
- FetchReq and LoadReq held continuously, WAIT_CYCLES=0:
  - Fixed priority: only LoadGnt every cycle, FetchGnt never.
  - ROUND_ROBIN_EN: grants alternate L,F,L,F, and Valids alternate accordingly.
- Back-to-back fetches at 0x0000..0x0003 -> four consecutive FetchValid pulses with no gap; data equals ROM contents in order.
- ResetN low one cycle during ACCESS with WAIT_CYCLES=5 -> all outputs 0 immediately; no Valid after release; next request serviced normally.
- FetchAddr=16'hFFFF -> RomAddress=16'hFFFF; FetchData=ROM[0xFFFF]; no wrap or overflow artefact.

Source files
------------

// File: rtl/rom_port_arbiter_if.sv
// ROM port arbiter bus: fetch and load request/grant/data
// channels plus the shared ROM address/data pair.
interface rom_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              FetchReq;
    logic [ADDR_W-1:0] FetchAddr;
    logic              FetchGnt;
    logic              FetchValid;
    logic [DATA_W-1:0] FetchData;
    logic              LoadReq;
    logic [ADDR_W-1:0] LoadAddr;
    logic              LoadGnt;
    logic              LoadValid;
    logic [DATA_W-1:0] LoadData;
    logic [ADDR_W-1:0] RomAddress;
    logic [DATA_W-1:0] RomData;
    logic              Busy;

    modport slave (
        input  FetchReq, FetchAddr, LoadReq, LoadAddr, RomData,
        output FetchGnt, FetchValid, FetchData,
        output LoadGnt, LoadValid, LoadData, RomAddress, Busy
    );

    modport master (
        output FetchReq, FetchAddr, LoadReq, LoadAddr, RomData,
        input  FetchGnt, FetchValid, FetchData,
        input  LoadGnt, LoadValid, LoadData, RomAddress, Busy
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// Shares one ROM port between fetch and load with a fixed wait count.
// Optional macro ROM_ARB_ROUND_ROBIN_EN: round-robin instead of load-first.
module rom_port_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 0,
    parameter int CNT_W       = 4
) (
    input  logic               Clk,
    input  logic               ResetN,
    rom_port_arbiter_if.slave  bus
);
    typedef enum logic { IDLE, ACCESS } state_t;
    typedef enum logic { FETCH, LOAD } owner_t;

    state_t            state_q;
    owner_t            owner_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] fdata_q, ldata_q;
    logic              fvalid_q, lvalid_q;
    logic              accept;
    logic              win_load;
    logic              fetch_gnt, load_gnt, any_gnt;

`ifdef ROM_ARB_ROUND_ROBIN_EN
    owner_t            last_q;
`endif

    // Accept when idle or on the completion cycle of the current access
    always_comb begin
        accept = (state_q == IDLE) || (cnt_q == '0);
`ifdef ROM_ARB_ROUND_ROBIN_EN
        if (bus.FetchReq && bus.LoadReq)
            win_load = (last_q == FETCH);
        else
            win_load = bus.LoadReq;
`else
        win_load = bus.LoadReq;
`endif
        fetch_gnt  = accept && bus.FetchReq && !win_load;
        load_gnt   = accept && bus.LoadReq && win_load;
        any_gnt    = fetch_gnt || load_gnt;
        rom_addr_d = win_load ? bus.LoadAddr : bus.FetchAddr;
    end

    // Access sequencer: wait count, capture into owner's register, re-accept
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q    <= IDLE;
            owner_q    <= FETCH;
            cnt_q      <= '0;
            rom_addr_q <= '0;
            fdata_q    <= '0;
            ldata_q    <= '0;
            fvalid_q   <= 1'b0;
            lvalid_q   <= 1'b0;
`ifdef ROM_ARB_ROUND_ROBIN_EN
            last_q     <= FETCH;
`endif
        end else begin
            fvalid_q <= 1'b0;
            lvalid_q <= 1'b0;
            if (state_q == ACCESS) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end else begin
                    if (owner_q == LOAD) begin
                        ldata_q  <= bus.RomData;
                        lvalid_q <= 1'b1;
                    end else begin
                        fdata_q  <= bus.RomData;
                        fvalid_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
            end
            if (any_gnt) begin
                rom_addr_q <= rom_addr_d;
                owner_q    <= load_gnt ? LOAD : FETCH;
                cnt_q      <= CNT_W'(WAIT_CYCLES);
                state_q    <= ACCESS;
`ifdef ROM_ARB_ROUND_ROBIN_EN
                last_q     <= load_gnt ? LOAD : FETCH;
`endif
            end
        end
    end

    // Grants are forced low while reset is asserted
    assign bus.FetchGnt   = fetch_gnt && ResetN;
    assign bus.LoadGnt    = load_gnt && ResetN;
    assign bus.FetchValid = fvalid_q;
    assign bus.FetchData  = fdata_q;
    assign bus.LoadValid  = lvalid_q;
    assign bus.LoadData   = ldata_q;
    assign bus.RomAddress = rom_addr_q;
    assign bus.Busy       = (state_q == ACCESS);
endmodule
